// File: rtl/axil_nco_pkg.sv
// Shared register map, CTRL bit positions and response codes for the NCO
// register block.
package axil_nco_pkg;

  localparam logic [7:0] REG_STEP   = 8'h00;
  localparam logic [7:0] REG_CTRL   = 8'h04;
  localparam logic [7:0] REG_STATUS = 8'h08;
  localparam logic [7:0] REG_CNT    = 8'h0C;
  localparam logic [7:0] REG_ID     = 8'h10;

  localparam int CTRL_STEP_EN     = 0;
  localparam int CTRL_DITHER_EN   = 1;
  localparam int CTRL_COMMIT      = 2;
  localparam int CTRL_AUTO_COMMIT = 3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic auto_commit;
    logic dither_en;
    logic step_en;
  } ctrl_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level input.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/axil_nco_regs.sv
// AXI4-Lite register block for the NCO step (shadow + commit) and DSM control,
// with lock status read-back.
module axil_nco_regs
  import axil_nco_pkg::*;
#(
  parameter int          ACC_WIDTH  = 32,
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] RESET_STEP = 32'h0000_0000,
  parameter logic [31:0] ID_VALUE   = 32'h4D41_5348
) (
  input  logic                  clk_100mhz_mmcm_out,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [31:0]           s_axil_wdata,
  input  logic [3:0]            s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [31:0]           s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  input  logic                  locked_in,
  output logic [ACC_WIDTH-1:0]  nco_step,
  output logic                  nco_step_valid,
  output logic                  nco_step_enable,
  output logic                  dither_enable
);

  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [31:0]           w_data_q;
  logic [3:0]            w_strb_q;
  logic                  bvalid_q, rvalid_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [31:0]           rdata_q;
  logic [ACC_WIDTH-1:0]  shadow, step_q;
  ctrl_t                 ctrl_q;
  logic [15:0]           commit_cnt;
  logic                  step_vld_q;
  logic                  locked_s;

  sync_2ff u_lock_sync (
    .clk (clk_100mhz_mmcm_out),
    .rst (RST),
    .d   (locked_in),
    .q   (locked_s)
  );

  assign s_axil_awready  = !RST && !aw_held && !bvalid_q;
  assign s_axil_wready   = !RST && !w_held && !bvalid_q;
  assign s_axil_arready  = !RST && !rvalid_q;
  assign s_axil_bvalid   = bvalid_q;
  assign s_axil_bresp    = bresp_q;
  assign s_axil_rvalid   = rvalid_q;
  assign s_axil_rresp    = rresp_q;
  assign s_axil_rdata    = rdata_q;
  assign nco_step        = step_q;
  assign nco_step_valid  = step_vld_q;
  assign nco_step_enable = ctrl_q.step_en;
  assign dither_enable   = ctrl_q.dither_en;

  logic aw_hs, w_hs, ar_hs, wr_fire;
  assign aw_hs   = s_axil_awvalid && s_axil_awready;
  assign w_hs    = s_axil_wvalid && s_axil_wready;
  assign ar_hs   = s_axil_arvalid && s_axil_arready;
  // The write lands on the edge where the second half arrives, so a channel
  // handshaking this cycle is used straight from the bus.
  assign wr_fire = (aw_held || aw_hs) && (w_held || w_hs);

  logic [ADDR_WIDTH-1:0] wr_word, rd_word;
  logic [31:0]           wr_data;
  logic [3:0]            wr_strb;
  assign wr_word = (aw_held ? aw_addr_q : s_axil_awaddr) & WORD_MASK;
  assign wr_data = w_held ? w_data_q : s_axil_wdata;
  assign wr_strb = w_held ? w_strb_q : s_axil_wstrb;
  assign rd_word = s_axil_araddr & WORD_MASK;

  logic sel_step, sel_ctrl, sel_known, do_commit;
  assign sel_step  = wr_word == ADDR_WIDTH'(REG_STEP);
  assign sel_ctrl  = wr_word == ADDR_WIDTH'(REG_CTRL);
  assign sel_known = sel_step || sel_ctrl ||
                     wr_word == ADDR_WIDTH'(REG_STATUS) ||
                     wr_word == ADDR_WIDTH'(REG_CNT) ||
                     wr_word == ADDR_WIDTH'(REG_ID);
  assign do_commit = wr_fire &&
                     ((sel_ctrl && wr_strb[0] && wr_data[CTRL_COMMIT]) ||
                      (sel_step && ctrl_q.auto_commit));

  logic [31:0] step_merged;
  always_comb begin
    step_merged = 32'(shadow);
    for (int b = 0; b < 4; b++)
      if (wr_strb[b]) step_merged[8*b +: 8] = wr_data[8*b +: 8];
  end

  logic [31:0] rd_data;
  logic [1:0]  rd_resp;
  always_comb begin
    rd_data = 32'h0;
    rd_resp = RESP_OKAY;
    if (rd_word == ADDR_WIDTH'(REG_STEP))
      rd_data = 32'(shadow);
    else if (rd_word == ADDR_WIDTH'(REG_CTRL))
      rd_data = {28'h0, ctrl_q.auto_commit, 1'b0, ctrl_q.dither_en, ctrl_q.step_en};
    else if (rd_word == ADDR_WIDTH'(REG_STATUS))
      rd_data = {30'h0, shadow != step_q, locked_s};
    else if (rd_word == ADDR_WIDTH'(REG_CNT))
      rd_data = {16'h0, commit_cnt};
    else if (rd_word == ADDR_WIDTH'(REG_ID))
      rd_data = ID_VALUE;
    else
      rd_resp = RESP_SLVERR;
  end

  always_ff @(posedge clk_100mhz_mmcm_out) begin
    if (RST) begin
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      shadow     <= RESET_STEP[ACC_WIDTH-1:0];
      step_q     <= RESET_STEP[ACC_WIDTH-1:0];
      ctrl_q     <= '{auto_commit: 1'b0, dither_en: 1'b0, step_en: 1'b1};
      commit_cnt <= '0;
      step_vld_q <= 1'b0;
    end else begin
      step_vld_q <= do_commit;
      if (wr_fire) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= sel_known ? RESP_OKAY : RESP_SLVERR;
        if (sel_step) shadow <= step_merged[ACC_WIDTH-1:0];
        if (sel_ctrl && wr_strb[0])
          ctrl_q <= '{auto_commit: wr_data[CTRL_AUTO_COMMIT],
                      dither_en:   wr_data[CTRL_DITHER_EN],
                      step_en:     wr_data[CTRL_STEP_EN]};
      end else begin
        if (aw_hs) begin
          aw_held   <= 1'b1;
          aw_addr_q <= s_axil_awaddr;
        end
        if (w_hs) begin
          w_held   <= 1'b1;
          w_data_q <= s_axil_wdata;
          w_strb_q <= s_axil_wstrb;
        end
        if (bvalid_q && s_axil_bready) bvalid_q <= 1'b0;
      end
      // Auto-commit must see the byte-merged value being written this cycle.
      if (do_commit) begin
        step_q     <= sel_step ? step_merged[ACC_WIDTH-1:0] : shadow;
        commit_cnt <= commit_cnt + 16'd1;
      end
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data;
        rresp_q  <= rd_resp;
      end else if (rvalid_q && s_axil_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

endmodule

// File: doc/axil_nco_regs.md
Name: axil_nco_regs

Overview:
AXI4-Lite responder register block holding the NCO frequency-control and DSM control registers. It sits between the JTAG-to-AXI-Lite master and dsm_core.
- Accepts register writes and reads from the master.
- Double-buffers the NCO step through a shadow register and a commit mechanism.
- Drives nco_step, nco_step_enable and dither_enable into the DSM core.
- Reports clock-lock status for read-back.

Parameters:
ACC_WIDTH, 32, NCO step width (ACC_INT_WIDTH + ACC_FRAC_WIDTH); must be <= 32
ADDR_WIDTH, 8, AXI-Lite byte address width
RESET_STEP, 32'h0000_0000, reset value of shadow and active step
ID_VALUE, 32'h4D41_5348, constant returned at ID register

Ports:
clk_100mhz_mmcm_out  input  1  system clock
RST  input  1  synchronous reset, active-high
s_axil_awaddr  input  ADDR_WIDTH  write address
s_axil_awvalid  input  1  write address valid
s_axil_awready  output  1  write address ready
s_axil_wdata  input  32  write data
s_axil_wstrb  input  4  byte strobes
s_axil_wvalid  input  1  write data valid
s_axil_wready  output  1  write data ready
s_axil_bresp  output  2  write response
s_axil_bvalid  output  1  write response valid
s_axil_bready  input  1  write response ready
s_axil_araddr  input  ADDR_WIDTH  read address
s_axil_arvalid  input  1  read address valid
s_axil_arready  output  1  read address ready
s_axil_rdata  output  32  read data
s_axil_rresp  output  2  read response
s_axil_rvalid  output  1  read data valid
s_axil_rready  input  1  read data ready
locked_in  input  1  MMCM locked, asynchronous to this clock
nco_step  output  ACC_WIDTH  active NCO step
nco_step_valid  output  1  one-cycle pulse on each step commit
nco_step_enable  output  1  CTRL.STEP_EN
dither_enable  output  1  CTRL.DITHER_EN

Behaviour:
- Reset is RST, synchronous, active-high; clock is clk_100mhz_mmcm_out.
- While RST is high:
  - all ready/valid outputs are 0; bresp = rresp = 0; rdata = 0.
  - nco_step = shadow = RESET_STEP; nco_step_valid = 0.
  - nco_step_enable = 1; dither_enable = 0; commit count = 0.
- Register map (word-aligned, addr[1:0] ignored):
  - 0x00 STEP RW: shadow step, bits [ACC_WIDTH-1:0]; upper bits read 0.
  - 0x04 CTRL RW:
    - bit0 STEP_EN.
    - bit1 DITHER_EN.
    - bit2 COMMIT: write-1 self-clearing, reads 0.
    - bit3 AUTO_COMMIT.
  - 0x08 STATUS RO:
    - bit0 locked (2-flop synchroniser).
    - bit1 pending (shadow != active).
  - 0x0C COMMIT_COUNT RO: 16-bit, wraps 0xFFFF -> 0.
  - 0x10 ID RO: ID_VALUE.
  - Any other address: read returns 0 with RRESP=SLVERR (2'b10); write has no effect and BRESP=SLVERR. Writes to RO registers: no effect, BRESP=OKAY.
- Write channel:
  - awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
  - AW and W are captured independently in either order.
  - The register update happens in the cycle after both are held. bvalid rises in that same cycle and holds until bready.
  - AW and W handshaking in the same cycle N -> register visible and bvalid=1 at N+1.
  - Only one write is outstanding; no new AW/W is accepted while bvalid=1.
- wstrb applies per byte to STEP and CTRL; CTRL bits live in byte 0.
- Commit: copies shadow to nco_step, pulses nco_step_valid for 1 cycle, increments COMMIT_COUNT. It occurs in the same cycle as the register update when either:
  - CTRL is written with bit2=1, or
  - STEP is written while AUTO_COMMIT=1 (post-write value).
- A CTRL write setting COMMIT and changing other bits applies all of them in one cycle.
- Read channel:
  - arready = !rvalid.
  - AR handshake at N -> rvalid=1 at N+1, with rdata sampled from register state at N. rvalid holds until rready.
- Simultaneous read and write of the same register in one cycle: the read returns the pre-write value.
- Reads and writes proceed concurrently; there is no arbitration.
- RST mid-transaction drops all held addresses/data and pending responses; no response is issued afterwards.

Decomposition:
- Package axil_nco_pkg holds:
  - register offset localparams.
  - CTRL bit index constants.
  - RESP_OKAY / RESP_SLVERR.
  - ctrl_t packed struct {auto_commit, dither_en, step_en}.
- One sub-module, sync_2ff, for locked_in. The rest stays flat.

Test Plan:
- Reset -> nco_step=0, nco_step_enable=1, dither_enable=0; read ID -> 0x4D415348, RRESP=OKAY, rvalid one cycle after AR handshake.
- Write STEP=0x0123_4567 (AUTO_COMMIT=0) -> nco_step unchanged, STATUS.pending=1; then write CTRL=0x5 -> nco_step=0x0123_4567 and a single nco_step_valid pulse in the B-valid cycle; COMMIT_COUNT=1; pending=0.
- Set CTRL=0x9, write STEP=0x00AB_CDEF with W leading AW by 3 cycles -> bvalid exactly 1 cycle after AW handshake, nco_step=0x00AB_CDEF, nco_step_valid pulse.
- Write STEP=0xFFFF_FFFF with wstrb=4'b0010 -> shadow byte1 only = 0xFF, other bytes retained.
- Access address 0x20 -> read RRESP=SLVERR, rdata=0; write BRESP=SLVERR, no state change.
- Hold bready=0 for 5 cycles -> bvalid held, awready/wready=0; assert RST during the stall -> all outputs return to reset values the next cycle. Toggle locked_in -> STATUS.locked follows within 3 cycles.
